vga_sram_pattern_gen: RTL and testbench

Fills the SRAM framebuffer with a test pattern so the VGA SRAM display path has something to scan out. It is the writer for the frame that the display reads. It walks every visible pixel in row-major order and issues one write per pixel over a valid/ready handshake to the SRAM controller. When the last pixel has been accepted, it asserts `pattern_done`, which gates the display.

---
 rtl/vga_sram_pattern_gen.sv | 125 ++++++++++++
 tb/tb_vga_sram_pattern_gen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sram_pattern_gen.sv
// Fills the SRAM framebuffer with a test pattern, one pixel write per accept, row-major.
// Define VGA_SRAM_PATTERN_GEN_CHECKER_EN to replace the gradient pattern with a 16x16 checkerboard.
module vga_sram_pattern_gen #(
  parameter int unsigned ADDR_BITS = 20,
  parameter int unsigned DATA_BITS = 16,
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned V_VISIBLE = 480
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 sram_wr_ready,
  output logic                 sram_wr_valid,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [DATA_BITS-1:0] sram_data,
  output logic                 busy,
  output logic                 pattern_done
);

  localparam int unsigned CW = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
  localparam int unsigned RW = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [ADDR_BITS-1:0] addr_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, busy_d, done_d;
  logic                 accept;
  logic                 last_col, last_row;

  // Pixel word for (col,row); column/row bits beyond the counter widths read as 0.
  function automatic logic [15:0] pixel_word(input logic [CW-1:0] col, input logic [RW-1:0] row);
`ifdef VGA_SRAM_PATTERN_GEN_CHECKER_EN
    return (1'(32'(col) >> 4) ^ 1'(32'(row) >> 4)) ? 16'hFFF0 : 16'h0000;
`else
    return {4'(col), 4'(row), 4'(32'(col) >> 4), 4'h0};
`endif
  endfunction

  assign accept   = sram_wr_valid && sram_wr_ready;
  assign last_col = (col_q == CW'(H_VISIBLE - 1));
  assign last_row = (row_q == RW'(V_VISIBLE - 1));

  // Next state, next counters and next registered outputs.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    addr_d  = sram_addr;
    data_d  = sram_data;
    valid_d = sram_wr_valid;
    busy_d  = busy;
    done_d  = pattern_done;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WRITE;
          col_d   = '0;
          row_d   = '0;
          addr_d  = '0;
          data_d  = DATA_BITS'(pixel_word('0, '0));
          valid_d = 1'b1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end
      S_WRITE: begin
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              state_d = S_DONE;
              valid_d = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
          addr_d = sram_addr + ADDR_BITS'(1);
          data_d = DATA_BITS'(pixel_word(col_d, row_d));
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
      end
    endcase
  end

  // State, counters and all outputs are registered; reset clears everything at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      col_q         <= '0;
      row_q         <= '0;
      sram_addr     <= '0;
      sram_data     <= '0;
      sram_wr_valid <= 1'b0;
      busy          <= 1'b0;
      pattern_done  <= 1'b0;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      sram_addr     <= addr_d;
      sram_data     <= data_d;
      sram_wr_valid <= valid_d;
      busy          <= busy_d;
      pattern_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_vga_sram_pattern_gen.sv
// Scoreboard bench for vga_sram_pattern_gen: expected writes are queued at each start,
// a negedge monitor pops and compares on every accepted write and models the SRAM image.
module tb_vga_sram_pattern_gen;

`ifdef VGA_SRAM_PATTERN_GEN_CHECKER_EN
  localparam int unsigned H = 32;
  localparam int unsigned V = 32;
`else
  localparam int unsigned H = 4;
  localparam int unsigned V = 3;
`endif
  localparam int unsigned AB = 20;
  localparam int unsigned DB = 16;
  localparam int unsigned N  = H * V;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          sram_wr_ready = 1'b0;
  logic          sram_wr_valid;
  logic [AB-1:0] sram_addr;
  logic [DB-1:0] sram_data;
  logic          busy;
  logic          pattern_done;

  typedef struct packed {
    logic [AB-1:0] addr;
    logic [DB-1:0] data;
  } wr_t;

  wr_t           sb[$];
  logic [DB-1:0] image[N];
  int            errors = 0;
  int            checks = 0;

  vga_sram_pattern_gen #(
    .ADDR_BITS(AB), .DATA_BITS(DB), .H_VISIBLE(H), .V_VISIBLE(V)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sram_wr_ready(sram_wr_ready),
    .sram_wr_valid(sram_wr_valid), .sram_addr(sram_addr), .sram_data(sram_data),
    .busy(busy), .pattern_done(pattern_done)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_pix(int c, int r);
`ifdef VGA_SRAM_PATTERN_GEN_CHECKER_EN
    return ((((c >> 4) ^ (r >> 4)) & 1) != 0) ? 16'hFFF0 : 16'h0000;
`else
    return {4'(c & 15), 4'(r & 15), 4'((c >> 4) & 15), 4'h0};
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_frame();
    for (int r = 0; r < int'(V); r++)
      for (int c = 0; c < int'(H); c++)
        sb.push_back('{addr: AB'(r * int'(H) + c), data: DB'(exp_pix(c, r))});
    for (int i = 0; i < int'(N); i++) image[i] = 16'hDEAD;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_image(input string name);
    int bad;
    bad = 0;
    for (int r = 0; r < int'(V); r++)
      for (int c = 0; c < int'(H); c++)
        if (image[r * int'(H) + c] !== exp_pix(c, r)) bad++;
    check(name, 32'(bad), 32'd0);
  endtask

  // Steps until pattern_done, counting valid cycles; optionally randomizes ready and pulses start.
  task automatic wait_done(input int bound, input bit rand_ready, output int valid_cycles);
    valid_cycles = 0;
    for (int i = 0; i < bound; i++) begin
      if (pattern_done) break;
      if (sram_wr_valid) valid_cycles++;
      if (rand_ready) begin
        sram_wr_ready = 1'($urandom_range(0, 1));
        start = (i == 5 || i == 9);
      end
      step();
      start = 1'b0;
    end
    sram_wr_ready = 1'b1;
    check("done_reached", 32'(pattern_done), 32'd1);
  endtask

  // Monitor: compares each accepted write against the scoreboard and checks stall stability.
  logic          stall_prev = 1'b0;
  logic          expect_done = 1'b0;
  logic [AB-1:0] held_addr;
  logic [DB-1:0] held_data;
  always @(negedge clk) begin
    wr_t e;
    if (!reset_n) begin
      stall_prev  = 1'b0;
      expect_done = 1'b0;
    end else begin
      if (expect_done) begin
        check("done_after_last", 32'(pattern_done), 32'd1);
        check("valid_after_last", 32'(sram_wr_valid), 32'd0);
        check("busy_after_last", 32'(busy), 32'd0);
        expect_done = 1'b0;
      end
      if (stall_prev) begin
        check("valid_held", 32'(sram_wr_valid), 32'd1);
        check("addr_stable", 32'(sram_addr), 32'(held_addr));
        check("data_stable", 32'(sram_data), 32'(held_data));
      end
      stall_prev = 1'b0;
      if (sram_wr_valid) begin
        if (sram_wr_ready) begin
          if (sb.size() == 0) begin
            check("spurious_write", 32'(sram_addr), 32'hFFFFFFFF);
          end else begin
            e = sb.pop_front();
            check("wr_addr", 32'(sram_addr), 32'(e.addr));
            check("wr_data", 32'(sram_data), 32'(e.data));
            if (int'(sram_addr) < int'(N)) image[int'(sram_addr)] = sram_data;
            if (sb.size() == 0) expect_done = 1'b1;
          end
        end else begin
          stall_prev = 1'b1;
          held_addr  = sram_addr;
          held_data  = sram_data;
        end
      end
    end
  end

  initial begin
    int vc;
    int guard;

    repeat (3) step();
    check("rst_valid", 32'(sram_wr_valid), 32'd0);
    check("rst_addr", 32'(sram_addr), 32'd0);
    check("rst_data", 32'(sram_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(pattern_done), 32'd0);
    reset_n = 1'b1;
    repeat (2) step();
    check("idle_valid", 32'(sram_wr_valid), 32'd0);

    // Full fill with ready held high.
    sram_wr_ready = 1'b1;
    push_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    check("first_valid", 32'(sram_wr_valid), 32'd1);
    check("first_addr", 32'(sram_addr), 32'd0);
    check("first_busy", 32'(busy), 32'd1);
    wait_done(4 * int'(N) + 10, 1'b0, vc);
    check("frame_cycles", 32'(vc), 32'(N));
    check("sb_empty_1", 32'(sb.size()), 32'd0);
    check_image("image_1");
`ifdef VGA_SRAM_PATTERN_GEN_CHECKER_EN
    check("pix_16_0", 32'(image[16]), 32'hFFF0);
    check("pix_16_16", 32'(image[16 * 32 + 16]), 32'h0000);
    check("pix_0_16", 32'(image[16 * 32]), 32'hFFF0);
`else
    check("pix_addr5", 32'(image[5]), 32'h1100);
    check("pix_addr3", 32'(image[3]), 32'h3000);
    check("pix_addr11", 32'(image[11]), 32'h3200);
`endif

    // Start in DONE clears pattern_done; fill with random ready and mid-frame start pulses.
    push_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    check("restart_done_clr", 32'(pattern_done), 32'd0);
    check("restart_valid", 32'(sram_wr_valid), 32'd1);
    wait_done(20 * int'(N) + 20, 1'b1, vc);
    check("sb_empty_2", 32'(sb.size()), 32'd0);
    check_image("image_2");
    repeat (3) step();
    check("done_held", 32'(pattern_done), 32'd1);
    check("done_no_valid", 32'(sram_wr_valid), 32'd0);

    // Reset asserted while addr 6 is presented aborts the frame.
    push_frame();
    start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (sram_addr != AB'(6) && guard < 50) begin
      step();
      guard++;
    end
    check("reach_addr6", 32'(sram_addr), 32'd6);
    #2 reset_n = 1'b0;
    #1;
    check("arst_valid", 32'(sram_wr_valid), 32'd0);
    check("arst_addr", 32'(sram_addr), 32'd0);
    check("arst_data", 32'(sram_data), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(pattern_done), 32'd0);
    sb.delete();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (5) step();
    check("post_rst_valid", 32'(sram_wr_valid), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_done", 32'(pattern_done), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
